// File: rtl/stopwatch_ctrl.sv
// Run-control front end for the two-digit seconds stopwatch: button sync/debounce,
// IDLE/RUN/PAUSE control, tick prescaler. Define STOPWATCH_DEBOUNCE_EN to build the debouncers.
module stopwatch_ctrl #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       tick,
  output logic       clear_out,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("stopwatch_ctrl: DIV must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_db_chk
    $error("stopwatch_ctrl: DB_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  // Bit 0 carries the start button, bit 1 the clear button.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] s_q, s_d;
  logic [1:0] deb;
  logic [1:0] deb_dly_q, deb_dly_d;
  logic [1:0] press;
  logic       start_press, clr_press;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;

  always_comb begin
    sync1_d   = {btn_clear, btn_start};
    s_d       = sync1_q;
    deb_dly_d = deb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      s_q       <= '0;
      deb_dly_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      deb_dly_q <= deb_dly_d;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]          deb_q, deb_d;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;

  // A level is accepted only after it has differed from deb for DB_CYCLES edges in a row.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
        deb_d[i]    = s_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign deb = deb_q;
`else
  assign deb = s_q;
`endif

  assign press       = deb & ~deb_dly_q;
  assign start_press = press[0];
  assign clr_press   = press[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    if (clr_press) begin
      state_d = IDLE;
    end else if (start_press) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    // Prescaler follows the current state, so a start press on the wrap edge still ticks.
    case (state_q)
      RUN: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAUSE:   cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase

    if (clr_press) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end

    clear_d   = clr_press;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign state     = state_q;
  assign tick      = tick_q;
  assign clear_out = clear_q;
  assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table of button presses with a scoreboard queue,
// plus hand-written tick-train, pause/resume, clear-priority, bounce and reset sequences.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clk;
  logic       reset;
  logic       btn_start;
  logic       btn_clear;
  logic       tick;
  logic       clear_out;
  logic       running;
  logic [1:0] state;

  stopwatch_ctrl #(
    .DIV       (DIV),
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .tick      (tick),
    .clear_out (clear_out),
    .running   (running),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       cl;
    logic [1:0] exp_st;
    logic       exp_clr;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic       run;
    logic       clr;
  } exp_t;

  vec_t       vecs[10];
  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] cur_st;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Raise the requested buttons, verify nothing happens before LAT edges, then check the outcome.
  task automatic press(input logic st, input logic cl, input logic [1:0] exp_st, input logic exp_clr);
    exp_t e;
    exp_t got;
    btn_start = st;
    btn_clear = cl;
    e.st  = exp_st;
    e.run = (exp_st == S_RUN);
    e.clr = exp_clr;
    sb_q.push_back(e);
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      chk("hold_state", int'(state), int'(cur_st));
      chk("hold_clear", int'(clear_out), 0);
    end
    step();
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      got = sb_q.pop_front();
      chk("press_state",   int'(state),     int'(got.st));
      chk("press_running", int'(running),   int'(got.run));
      chk("press_clear",   int'(clear_out), int'(got.clr));
    end
    cur_st    = exp_st;
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic first_tick(output int n);
    n = 99;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_ticks(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tick) c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c;
    int j;
    int w;
    int last;
    int changes;
    logic [1:0] prev;

    vecs[0] = '{1'b1, 1'b0, S_RUN,   1'b0};
    vecs[1] = '{1'b1, 1'b0, S_PAUSE, 1'b0};
    vecs[2] = '{1'b1, 1'b0, S_RUN,   1'b0};
    vecs[3] = '{1'b0, 1'b1, S_IDLE,  1'b1};
    vecs[4] = '{1'b0, 1'b1, S_IDLE,  1'b1};
    vecs[5] = '{1'b1, 1'b0, S_RUN,   1'b0};
    vecs[6] = '{1'b1, 1'b1, S_IDLE,  1'b1};
    vecs[7] = '{1'b1, 1'b0, S_RUN,   1'b0};
    vecs[8] = '{1'b1, 1'b0, S_PAUSE, 1'b0};
    vecs[9] = '{1'b0, 1'b1, S_IDLE,  1'b1};

    reset     = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cur_st    = S_IDLE;
    #2 reset = 1'b0;
    #1;
    chk("rst_state",   int'(state),     0);
    chk("rst_tick",    int'(tick),      0);
    chk("rst_running", int'(running),   0);
    chk("rst_clear",   int'(clear_out), 0);
    settle(2);
    reset = 1'b1;
    settle(3);

    for (int v = 0; v < 10; v++) begin
      press(vecs[v].st, vecs[v].cl, vecs[v].exp_st, vecs[v].exp_clr);
      settle(LAT + 2);
    end

    // Tick train from a fresh start
    press(1'b1, 1'b0, S_RUN, 1'b0);
    first_tick(n);
    chk("first_tick_delay", n, DIV);
    c = 0;
    last = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick) begin
        c++;
        chk("tick_period", i - last, DIV);
        last = i;
      end
    end
    chk("tick_count_40", c, 10);
    j = n + 40;

    // Pause with the prescaler holding 2
    w = LAT + 1;
    while ((j + w + LAT) % DIV != 2) w++;
    settle(w);
    press(1'b1, 1'b0, S_PAUSE, 1'b0);
    count_ticks(20, c);
    chk("pause_ticks", c, 0);
    chk("pause_state", int'(state), int'(S_PAUSE));
    press(1'b1, 1'b0, S_RUN, 1'b0);
    first_tick(n);
    chk("resume_tick_delay", n, 2);

    // Clear and start on the edge where the prescaler would wrap
    j = 0;
    w = LAT + 1;
    while ((j + w + LAT) % DIV != 0) w++;
    settle(w);
    press(1'b1, 1'b1, S_IDLE, 1'b1);
    chk("clr_pri_tick", int'(tick), 0);
    step();
    chk("clr_pri_clear_drop", int'(clear_out), 0);
    chk("clr_pri_tick_next", int'(tick), 0);
    count_ticks(12, c);
    chk("clr_pri_idle_ticks", c, 0);
    chk("clr_pri_state", int'(state), int'(S_IDLE));

`ifdef STOPWATCH_DEBOUNCE_EN
    changes = 0;
    prev = state;
    for (int i = 0; i < 30; i++) begin
      btn_start = ((i % 4) < 2);
      step();
      if (state != prev) changes++;
      prev = state;
    end
    btn_start = 1'b1;
    for (int i = 0; i < LAT + 6; i++) begin
      step();
      if (state != prev) changes++;
      prev = state;
    end
    chk("bounce_transitions", changes, 1);
    chk("bounce_state", int'(state), int'(S_RUN));
    btn_start = 1'b0;
    cur_st = S_RUN;
    settle(LAT + 2);
`else
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    chk("pulse_no_early", int'(state), int'(S_IDLE));
    step();
    chk("pulse_state", int'(state), int'(S_RUN));
    chk("pulse_running", int'(running), 1);
    cur_st = S_RUN;
    settle(LAT + 2);
`endif

    // Asynchronous reset in the middle of a RUN second
    press(1'b0, 1'b1, S_IDLE, 1'b1);
    settle(LAT + 2);
    press(1'b1, 1'b0, S_RUN, 1'b0);
    settle(2);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_state",   int'(state),     0);
    chk("async_rst_running", int'(running),   0);
    chk("async_rst_tick",    int'(tick),      0);
    chk("async_rst_clear",   int'(clear_out), 0);
    settle(2);
    reset = 1'b1;
    cur_st = S_IDLE;
    count_ticks(12, c);
    chk("post_rst_ticks", c, 0);
    chk("post_rst_state", int'(state), int'(S_IDLE));
    press(1'b1, 1'b0, S_RUN, 1'b0);
    first_tick(n);
    chk("post_rst_first_tick", n, DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run-control front end for the two-digit seconds stopwatch. It synchronises and debounces the raw start/stop and clear push-buttons and runs a three-state control machine. It divides the board clock into a one-cycle `tick` enable that drives the mod-10 stage, and issues a one-cycle `clear_out` that zeroes the mod-10/mod-6 counters. It sits directly upstream of the counter chain and replaces the free-running clock divider.

## Interface
- `DIV`, default 50_000_000: board-clock cycles per `tick`; must be ≥ 2.
- `DB_CYCLES`, default 500_000: cycles a synchronised button level must be stable before it is accepted; must be ≥ 1.
- `clk` input, 1 bit: single clock. All state is clocked on its rising edge.
- `reset` input, 1 bit: one clock; reset is asynchronous and active-low.
- `btn_start` input, 1 bit: raw start/stop button, active-high, asynchronous to `clk`.
- `btn_clear` input, 1 bit: raw clear button, active-high, asynchronous to `clk`.
- `tick` output, 1 bit: one-cycle count enable for the mod-10 counter.
- `clear_out` output, 1 bit: one-cycle synchronous clear for the counters.
- `running` output, 1 bit: high while the state is RUN.
- `state` output, 2 bits: IDLE=00, RUN=01, PAUSE=10. The value 11 never occurs.

## Operation
- **Input path, per button:**
  - A 2-flop synchroniser produces `s`.
  - The debouncer holds the accepted level `deb`.
  - `db_cnt` clears whenever `s == deb`. It increments while `s != deb`.
  - On the edge where `s != deb` and `db_cnt == DB_CYCLES-1`, `deb <= s` and `db_cnt <= 0`.
  - `deb_d` is `deb` delayed by one cycle.
  - The press pulse is `deb & ~deb_d`, i.e. a rising edge only. Release never acts.
- **State machine, evaluated on each edge:**
  - If a clear press is present, go to IDLE, irrespective of state or a simultaneous start press. Clear always wins.
  - Otherwise, on a start press: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - With no press, the state holds.
- **Prescaler `cnt`:**
  - Width is `$clog2(DIV)`.
  - In RUN it counts 0..DIV-1 and wraps to 0.
  - In PAUSE it holds its value, so a resumed second keeps its partial progress.
  - In IDLE, and on any clear press, it is forced to 0.
- **`tick` (registered):**
  - On the edge where the state is RUN and `cnt == DIV-1`, `tick <= 1` and `cnt <= 0`. Otherwise `tick <= 0`.
  - A start press on that same edge still produces the tick; the state becomes PAUSE.
  - A clear press on that same edge suppresses the tick.
- **`clear_out` (registered):** high for exactly one cycle after each edge where a clear press is present, including a clear press while already in IDLE.
- **`running` (registered):** equals `state == RUN`.
- **Reset:**
  - Asynchronous, at any time, including mid-count or mid-debounce.
  - State goes to IDLE.
  - `cnt`, `db_cnt`, synchroniser flops, `deb` and `deb_d` go to 0.
  - `tick = 0`, `clear_out = 0`, `running = 0`.
- **Button held through reset release:** it is accepted after debounce and acts as a press.

## Timing
- Raw button rise, stable, with no reset in between:
  - `s` rises 2 edges later.
  - `deb` rises DB_CYCLES edges after that.
  - The press pulse is high for the following cycle.
  - The state changes on the next edge.
- Glitches shorter than DB_CYCLES cycles on `s` produce no press.
- First `tick` after entering RUN from IDLE: DIV edges after the state-change edge.
- Steady RUN: `tick` period is exactly DIV cycles, with a duty cycle of 1 cycle.
- `running` and `state` update on the same edge as the transition.
- `clear_out` asserts one edge after the clear press is sampled.

## Configuration
- **`STOPWATCH_DEBOUNCE_EN` defined:** debouncer as described; `DB_CYCLES` applies.
- **`STOPWATCH_DEBOUNCE_EN` not defined:**
  - `deb = s` directly; no `db_cnt` is built and `DB_CYCLES` is ignored.
  - Press latency becomes 2 edges to `s`, then a pulse for one cycle.
  - All other behaviour is identical.

## Test plan
All scenarios use DIV=4, DB_CYCLES=3 and the macro defined unless stated.
- **Reset:**
  - Stimulus: drive `reset=0` mid-RUN with `cnt=2`, then release.
  - Required: `state=00`, `tick=0`, `running=0`, `clear_out=0` immediately; no tick until a new start press.
- **Start and tick train:**
  - Stimulus: stable `btn_start` press.
  - Required: RUN is reached 2+3+1 edges after the raw rise; then `tick` pulses exactly every 4 cycles; 10 ticks are counted over 40 cycles.
- **Pause/resume:**
  - Stimulus: pause the stopwatch when `cnt=2`, wait 20 cycles, then resume.
  - Required: no tick while in PAUSE; the first tick after resume occurs 2 edges after the resume edge.
- **Bounce rejection:**
  - Stimulus: toggle `btn_start` with 2-cycle high and low pulses for 30 cycles, then hold it high.
  - Required: exactly one state transition.
- **Clear priority:**
  - Stimulus: start and clear presses aligned to the same edge while in RUN at `cnt=3`.
  - Required: `state=IDLE`; no tick; `clear_out` high for 1 cycle; `cnt=0`.
- **Macro off:**
  - Stimulus: a 1-cycle-wide `btn_start` pulse.
  - Required: the state changes 3 edges after the raw rise.
